// File: rtl/mimosa_pkg.sv
// Shared energy/stress constants and indicator encoding for the creature controllers.
package mimosa_pkg;

    localparam int LEVEL_W = 8;

    localparam int TH_LOW  = 64;
    localparam int TH_MID  = 128;
    localparam int TH_HIGH = 192;

    localparam logic [1:0] IND_EMPTY = 2'd0;
    localparam logic [1:0] IND_LOW   = 2'd1;
    localparam logic [1:0] IND_MID   = 2'd2;
    localparam logic [1:0] IND_HIGH  = 2'd3;

    // Lower threshold of an indicator band (64 * ind), widened for signed-safe compares.
    function automatic logic [9:0] ind_floor(input logic [1:0] ind);
        return {2'b00, ind, 6'b00_0000};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running update prescaler: one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

    logic [15:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST_CNT) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    assign tick = (tick_cnt == LAST_CNT);

endmodule

// File: rtl/energy_regulator.sv
// Energy store with tick-paced inc/dec, feed saturation and a hysteretic indicator.
//
//   state      | meaning
//   IND_EMPTY  | level well below 64
//   IND_LOW    | level around 64..127
//   IND_MID    | level around 128..191
//   IND_HIGH   | level around 192..255
module energy_regulator
    import mimosa_pkg::*;
#(
    parameter int TICK_DIV    = 1024,
    parameter int INC_STEP    = 2,
    parameter int DEC_STEP    = 1,
    parameter int FEED_STEP   = 32,
    parameter int HYST        = 8,
    parameter int RESET_LEVEL = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_inc,
    input  logic               en_dec,
    input  logic [1:0]         stress_indicator,
    input  logic               feed,
    output logic [LEVEL_W-1:0] energy_level,
    output logic [1:0]         energy_indicator,
    output logic               exhausted
);

    localparam logic signed [9:0] INC_D   = 10'(INC_STEP);
    localparam logic signed [9:0] DEC_D   = 10'(DEC_STEP);
    localparam logic signed [9:0] DEC2_D  = 10'(2 * DEC_STEP);
    localparam logic signed [9:0] FEED_D  = 10'(FEED_STEP);
    localparam logic        [9:0] HYST_D  = 10'(HYST);
    localparam logic [LEVEL_W-1:0] RESET_L   = 8'(RESET_LEVEL);
    localparam logic [1:0]         RESET_IND = 2'(RESET_LEVEL >> 6);

    logic tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic signed [9:0]  tick_delta;
    logic signed [9:0]  feed_delta;
    logic signed [9:0]  level_sum;
    logic [LEVEL_W-1:0] level_next;

    // Feed and tick contributions are summed first so saturation happens once.
    always_comb begin
        tick_delta = '0;
        if (tick) begin
            if (en_inc && !en_dec) begin
                tick_delta = INC_D;
            end else if (en_dec && !en_inc) begin
                tick_delta = (stress_indicator == 2'b11) ? -DEC2_D : -DEC_D;
            end
        end
        feed_delta = feed ? FEED_D : '0;
        level_sum  = $signed({2'b00, energy_level}) + tick_delta + feed_delta;
        if (level_sum[9]) begin
            level_next = '0;
        end else if (level_sum[8]) begin
            level_next = '1;
        end else begin
            level_next = level_sum[7:0];
        end
    end

    logic [9:0] level_w;
    logic [9:0] ind_base;
    logic [1:0] ind_next;

    always_comb begin
        level_w  = {2'b00, energy_level};
        ind_base = ind_floor(energy_indicator);
        ind_next = energy_indicator;
        if (energy_indicator != IND_HIGH && level_w >= ind_base + 10'd64 + HYST_D) begin
            ind_next = energy_indicator + 2'd1;
        end else if (energy_indicator != IND_EMPTY && level_w < ind_base - HYST_D) begin
            ind_next = energy_indicator - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            energy_level     <= RESET_L;
            energy_indicator <= RESET_IND;
            exhausted        <= 1'b0;
        end else begin
            energy_level     <= level_next;
            energy_indicator <= ind_next;
            exhausted        <= (level_next == '0) && (energy_level != '0);
        end
    end

endmodule

// File: tb/tb_energy_regulator.sv
// Directed and random checks of energy_regulator against a cycle-level arithmetic model.
module tb_energy_regulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_inc;
    logic       en_dec;
    logic       feed;
    logic [1:0] stress;

    logic [7:0] lvl_d, lvl_s;
    logic [1:0] ind_d, ind_s;
    logic       exh_d, exh_s;

    energy_regulator dut_d (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_inc          (en_inc),
        .en_dec          (en_dec),
        .stress_indicator(stress),
        .feed            (feed),
        .energy_level    (lvl_d),
        .energy_indicator(ind_d),
        .exhausted       (exh_d)
    );

    energy_regulator #(
        .TICK_DIV   (4),
        .RESET_LEVEL(10)
    ) dut_s (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_inc          (en_inc),
        .en_dec          (en_dec),
        .stress_indicator(stress),
        .feed            (feed),
        .energy_level    (lvl_s),
        .energy_indicator(ind_s),
        .exhausted       (exh_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: index 0 = default parameters, 1 = TICK_DIV 4 / RESET_LEVEL 10.
    int m_cnt[2];
    int m_lvl[2];
    int m_ind[2];
    int m_exh[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int div, rl, d, nl, ni;
            div = (k == 0) ? 1024 : 4;
            rl  = (k == 0) ? 128 : 10;
            if (!rst_n) begin
                m_cnt[k] = 0;
                m_lvl[k] = rl;
                m_ind[k] = rl / 64;
                m_exh[k] = 0;
            end else begin
                d = 0;
                if (m_cnt[k] == div - 1) begin
                    if (en_inc && !en_dec)      d = 2;
                    else if (en_dec && !en_inc) d = (stress == 2'b11) ? -2 : -1;
                end
                if (feed) d = d + 32;
                nl = m_lvl[k] + d;
                if (nl < 0)   nl = 0;
                if (nl > 255) nl = 255;
                ni = m_ind[k];
                if (ni < 3 && m_lvl[k] >= 64 * (ni + 1) + 8)  ni = ni + 1;
                else if (ni > 0 && m_lvl[k] < 64 * ni - 8)    ni = ni - 1;
                m_exh[k] = (nl == 0 && m_lvl[k] != 0) ? 1 : 0;
                m_cnt[k] = (m_cnt[k] == div - 1) ? 0 : m_cnt[k] + 1;
                m_lvl[k] = nl;
                m_ind[k] = ni;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("lvl_d", int'(lvl_d), m_lvl[0]);
        chk("ind_d", int'(ind_d), m_ind[0]);
        chk("exh_d", int'(exh_d), m_exh[0]);
        chk("lvl_s", int'(lvl_s), m_lvl[1]);
        chk("ind_s", int'(ind_s), m_ind[1]);
        chk("exh_s", int'(exh_s), m_exh[1]);
    endtask

    task automatic drive(input bit i, input bit d, input logic [1:0] s, input bit f);
        en_inc = i;
        en_dec = d;
        stress = s;
        feed   = f;
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 8 && m_cnt[1] != 3; n++) cycle();
    endtask

    // Steers the small instance to an exact level without overshooting the target.
    task automatic goto_lvl(input int target);
        int diff;
        for (int n = 0; n < 2000 && m_lvl[1] != target; n++) begin
            diff = target - m_lvl[1];
            if (m_cnt[1] == 3) begin
                if (diff >= 2)       drive(1'b1, 1'b0, 2'd0, 1'b0);
                else if (diff <= -2) drive(1'b0, 1'b1, 2'd3, 1'b0);
                else                 drive(1'b0, 1'b1, 2'd0, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 2'd0, 1'b0);
            end
            cycle();
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        chk($sformatf("goto_%0d", target), int'(lvl_s), target);
    endtask

    initial begin
        int pulses, prev, steps, skips;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (3) cycle();
        chk("rst_lvl_d", int'(lvl_d), 128);
        chk("rst_ind_d", int'(ind_d), 2);
        chk("rst_exh_d", int'(exh_d), 0);
        chk("rst_lvl_s", int'(lvl_s), 10);
        chk("rst_ind_s", int'(ind_s), 0);

        // Stressed decrement on the fast instance; first tick on the default one.
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 2'd3, 1'b0);
        pulses = 0;
        for (int c = 1; c <= 1024; c++) begin
            cycle();
            pulses += int'(exh_s);
            if (c % 4 == 0 && c <= 20) chk("dec_seq", int'(lvl_s), 10 - 2 * (c / 4));
            if (c == 20)   chk("exh_at_zero", int'(exh_s), 1);
            if (c == 24)   chk("exh_no_refire", int'(exh_s), 0);
            if (c == 1023) chk("pre_tick_d", int'(lvl_d), 128);
        end
        chk("first_tick_d", int'(lvl_d), 126);
        chk("exh_once", pulses, 1);

        // Feed from empty to full: indicator must climb one state per cycle.
        drive(1'b0, 1'b0, 2'd0, 1'b1);
        prev = int'(ind_s);
        steps = 0;
        skips = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 9) drive(1'b0, 1'b0, 2'd0, 1'b0);
            cycle();
            if (c == 8) chk("feed_lvl", int'(lvl_s), 255);
            if (int'(ind_s) != prev) begin
                steps++;
                if (int'(ind_s) != prev + 1) skips++;
                prev = int'(ind_s);
            end
        end
        chk("feed_ind_steps", steps, 3);
        chk("feed_ind_skip", skips, 0);
        chk("feed_ind_final", int'(ind_s), 3);

        // Inc+dec cancel; feed and decrement on one tick saturate together.
        goto_lvl(250);
        wait_tick();
        drive(1'b1, 1'b1, 2'd3, 1'b0);
        cycle();
        chk("inc_dec_hold", int'(lvl_s), 250);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        cycle();
        wait_tick();
        drive(1'b0, 1'b1, 2'd0, 1'b1);
        cycle();
        chk("feed_sat", int'(lvl_s), 255);
        drive(1'b0, 1'b0, 2'd0, 1'b0);

        // Hysteresis around the 128 threshold.
        goto_lvl(100);
        repeat (2) cycle();
        chk("hys_100", int'(ind_s), 1);
        goto_lvl(120);
        goto_lvl(135);
        repeat (2) cycle();
        chk("hys_135", int'(ind_s), 1);
        goto_lvl(137);
        chk("hys_137_lag", int'(ind_s), 1);
        cycle();
        chk("hys_137_up", int'(ind_s), 2);
        goto_lvl(121);
        repeat (2) cycle();
        chk("hys_121", int'(ind_s), 2);
        goto_lvl(119);
        chk("hys_119_lag", int'(ind_s), 2);
        cycle();
        chk("hys_119_down", int'(ind_s), 1);

        // Reset landing on a tick cycle drops the pending increment.
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        wait_tick();
        rst_n = 1'b0;
        cycle();
        chk("rst_mid_lvl", int'(lvl_s), 10);
        chk("rst_mid_ind", int'(ind_s), 0);
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("rst_mid_hold", int'(lvl_s), 10);
        cycle();
        chk("rst_mid_tick", int'(lvl_s), 12);
        drive(1'b0, 1'b0, 2'd0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 1499) != 0);
            en_inc = 1'($urandom_range(0, 1));
            en_dec = 1'($urandom_range(0, 1));
            stress = 2'($urandom_range(0, 3));
            feed   = ($urandom_range(0, 15) == 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/energy_regulator.md
# energy_regulator

Owns the creature's 8-bit energy store and sequences its updates from the `physical_state_controller` requests `en_inc` and `en_dec`, plus a feed pulse. It sits beside `physical_state_controller`: it consumes that block's increment/decrement enables and its `stress_indicator`, and it returns the quantised `energy_indicator` that the controller uses to decide sleep and wake. Updates are paced by an internal tick prescaler. Quantisation uses hysteresis so the indicator does not chatter at thresholds.

## Interface
- `TICK_DIV`, 1024: clocks per update tick; legal range 2..65535.
- `INC_STEP`, 2: level increase per tick while sleeping (`en_inc`).
- `DEC_STEP`, 1: level decrease per tick while awake (`en_dec`); doubled under high stress.
- `FEED_STEP`, 32: level increase per cycle in which `feed` is high.
- `HYST`, 8: hysteresis band around each threshold; must be < 32.
- `RESET_LEVEL`, 128: value of `energy_level` after reset.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `en_inc` input 1: increase request, level-sensitive.
- `en_dec` input 1: decrease request, level-sensitive.
- `stress_indicator` input 2: current stress; 2'b11 doubles the decrement.
- `feed` input 1: feed request, applied in every cycle it is high.
- `energy_level` output 8: energy register.
- `energy_indicator` output 2: quantised level with hysteresis.
- `exhausted` output 1: one-cycle pulse when the level reaches 0.

## Operation
- **Prescaler.** Counter `tick_cnt` runs 0..TICK_DIV-1 and wraps to 0. The internal `tick` is high when `tick_cnt == TICK_DIV-1`.
- **Tick delta.** Computed only in a `tick` cycle; zero otherwise.
  - `en_inc` and not `en_dec`: +INC_STEP.
  - `en_dec` and not `en_inc`: -DEC_STEP, or -2*DEC_STEP if `stress_indicator == 2'b11`.
  - Both or neither: 0.
- **Feed delta.** +FEED_STEP when `feed` is high, else 0.
- **Level update.** `next = energy_level + tick_delta + feed_delta`.
  - Evaluate in 10-bit signed arithmetic.
  - Clamp to 0..255.
  - Simultaneous feed and tick are summed before clamping, never applied sequentially.
- **Indicator FSM.** States IND0..IND3, encoded as the output value. At most one step per cycle, evaluated on the registered `energy_level`.
  - Step up when `ind < 3` and `energy_level >= 64*(ind+1) + HYST`.
  - Step down when `ind > 0` and `energy_level < 64*ind - HYST`.
  - Otherwise hold.
- **Exhausted.** `exhausted` is high for exactly one cycle: the first cycle in which `energy_level` reads 0 after being nonzero. It does not re-fire while the level stays at 0.
- **Reset values** (when `rst_n` is low at a clock edge):
  - `tick_cnt` = 0.
  - `energy_level` = RESET_LEVEL.
  - `energy_indicator` = RESET_LEVEL >> 6.
  - `exhausted` = 0.
- **Reset mid-operation** discards any pending tick. The prescaler restarts a full period.

## Timing
- The first `tick` occurs TICK_DIV cycles after reset release, in the cycle with `tick_cnt == TICK_DIV-1`.
- `energy_level` reflects inputs sampled in cycle N at cycle N+1.
- `energy_indicator` lags `energy_level` by one cycle, i.e. 2 cycles from the inputs.
- `exhausted` is registered together with `energy_level`. It is asserted in the same cycle `energy_level` first shows 0.
- `en_inc`, `en_dec` and `stress_indicator` matter only in the `tick` cycle. They need no holding between ticks.
- A `feed` pulse of k cycles adds k*FEED_STEP, saturating.

## Structure
- **Package `mimosa_pkg`:**
  - `LEVEL_W` = 8.
  - Threshold constants 64/128/192.
  - Indicator encoding localparams (IND_EMPTY=0, IND_LOW=1, IND_MID=2, IND_HIGH=3).
  - Shared with `physical_state_controller` and the future stress regulator.
- **Sub-module `tick_prescaler`:**
  - Parameter TICK_DIV.
  - Ports: clk, rst_n, tick.
  - Reused by the stress and hunger regulators.
- Indicator FSM and level datapath stay in `energy_regulator`.

## Test plan
- **Reset.** Hold `rst_n` low 3 cycles with defaults. Expect `energy_level`=128, `energy_indicator`=2, `exhausted`=0; first tick at cycle 1024 after release.
- **Decrement with stress.** With TICK_DIV=4, RESET_LEVEL=10, `en_dec`=1, `stress_indicator`=3, expect the level to go 10→8→6→4→2→0 on successive ticks. `exhausted` pulses once at the 0 transition and stays low for later ticks.
- **Saturation and feed priority.** Start at level 250 with `feed`=1 for 1 cycle coinciding with a tick carrying `en_dec`. Expect 250+32-1 clamped to 255. `en_inc`+`en_dec` together on a tick leaves the level unchanged.
- **Hysteresis up.** Drive the level 120→135→137 with HYST=8. Expect the indicator to stay 1 at 135 and step to 2 one cycle after the level reads 137 (≥136). Falling back to 121 keeps it 2; it steps to 1 only at 119 (<120).
- **Multi-step jump.** Feed takes the level from 0 to 255 over 8 cycles. Expect the indicator to step 0→1→2→3 one step per cycle, never skipping a state.
- **Reset mid-tick.** Assert `rst_n` low when `tick_cnt`=TICK_DIV-1 with `en_inc`=1. Expect no increment to be applied: level = RESET_LEVEL and the prescaler restarts at 0.
